// File: rtl/enc_rr_arbiter.sv
// rtl/enc_rr_arbiter.sv - round-robin arbiter driving an 8-to-3 encoded grant link
// Grants one requester at a time, holds until release or hold timeout, then rotates.
module enc_rr_arbiter #(
  parameter int N_REQ    = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [7:0]         hold_cnt, hold_next;
  logic [N_REQ-1:0]   gnt_q, gnt_next;
  logic [IDX_W-1:0]   idx_q, idx_next;
  logic               timeout_q, timeout_next;

  logic [IDX_W:0]     idle_pick, rel_pick;
  logic [IDX_W-1:0]   after_owner;
  logic               owner_req, at_limit, release_now;

  // First set bit of r scanning start, start+1, ... with wrap; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] start);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + i[IDX_W-1:0];
      if (r[idx] && !res[IDX_W]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      hold_cnt  <= hold_next;
      gnt_q     <= gnt_next;
      idx_q     <= idx_next;
      timeout_q <= timeout_next;
    end
  end

  assign after_owner = idx_q + 1'b1;
  assign owner_req   = req[idx_q];
  assign at_limit    = (hold_cnt == HOLD_LIMIT);
  assign release_now = done | ~owner_req | at_limit;
  assign idle_pick   = rr_pick(req, ptr);
  // The releasing owner is masked so it queues behind everyone else.
  assign rel_pick    = rr_pick(req & ~gnt_q, after_owner);

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    hold_next    = hold_cnt;
    gnt_next     = gnt_q;
    idx_next     = idx_q;
    timeout_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (idle_pick[IDX_W]) begin
          state_next = S_GRANT;
          gnt_next   = {{(N_REQ-1){1'b0}}, 1'b1} << idle_pick[IDX_W-1:0];
          idx_next   = idle_pick[IDX_W-1:0];
          hold_next  = 8'd1;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_next     = after_owner;
          // A done or a dropped request in the limit cycle is an ordinary release.
          timeout_next = at_limit & ~done & owner_req;
          if (rel_pick[IDX_W]) begin
            gnt_next  = {{(N_REQ-1){1'b0}}, 1'b1} << rel_pick[IDX_W-1:0];
            idx_next  = rel_pick[IDX_W-1:0];
            hold_next = 8'd1;
          end else begin
            state_next = S_IDLE;
            gnt_next   = '0;
            idx_next   = '0;
            hold_next  = '0;
          end
        end else if (hold_cnt < HOLD_LIMIT) begin
          hold_next = hold_cnt + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = |gnt_q;
    timeout   = timeout_q;
  end

endmodule
